// File: rtl/segrx_pkg.sv
// rtl/segrx_pkg.sv - symbol codes, segment patterns, decode and expected sequence
package segrx_pkg;

   typedef enum logic [2:0] {
      SYM_UNK = 3'd0,
      SYM_S   = 3'd1,
      SYM_E   = 3'd2,
      SYM_N   = 3'd3,
      SYM_O   = 3'd4,
      SYM_L   = 3'd5,
      SYM_G   = 3'd6,
      SYM_U   = 3'd7
   } sym_t;

   // Segment order is a..g from bit6 down to bit0, active high.
   localparam logic [6:0] SEG_BLANK = 7'b0000000;
   localparam logic [6:0] SEG_S     = 7'b1011011;
   localparam logic [6:0] SEG_E     = 7'b1001111;
   localparam logic [6:0] SEG_N     = 7'b0010101;
   localparam logic [6:0] SEG_O     = 7'b1111110;
   localparam logic [6:0] SEG_L     = 7'b0001110;
   localparam logic [6:0] SEG_G     = 7'b1011111;
   localparam logic [6:0] SEG_U     = 7'b0111110;

   localparam logic [3:0] SEQ_LAST  = 4'd12;

   function automatic sym_t exp_sym(input logic [3:0] idx);
      case (idx)
         4'd0:    exp_sym = SYM_S;
         4'd1:    exp_sym = SYM_E;
         4'd2:    exp_sym = SYM_N;
         4'd3:    exp_sym = SYM_O;
         4'd4:    exp_sym = SYM_L;
         4'd5:    exp_sym = SYM_G;
         4'd6:    exp_sym = SYM_U;
         4'd7:    exp_sym = SYM_L;
         4'd8:    exp_sym = SYM_G;
         4'd9:    exp_sym = SYM_O;
         4'd10:   exp_sym = SYM_N;
         4'd11:   exp_sym = SYM_U;
         4'd12:   exp_sym = SYM_L;
         default: exp_sym = SYM_UNK;
      endcase
   endfunction

   function automatic sym_t seg_decode(input logic [6:0] pat);
      case (pat)
         SEG_S:   seg_decode = SYM_S;
         SEG_E:   seg_decode = SYM_E;
         SEG_N:   seg_decode = SYM_N;
         SEG_O:   seg_decode = SYM_O;
         SEG_L:   seg_decode = SYM_L;
         SEG_G:   seg_decode = SYM_G;
         SEG_U:   seg_decode = SYM_U;
         default: seg_decode = SYM_UNK;
      endcase
   endfunction

endpackage

// File: rtl/seg_stabilizer.sv
// rtl/seg_stabilizer.sv - synchronizes the segment bus and pulses accept once per stable pattern
module seg_stabilizer #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] seg_in,
   output logic [6:0] pat,
   output logic       accept
);

   logic [6:0] s1;
   logic [6:0] s2;
   logic [6:0] prev;
   logic [3:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1   <= '0;
         s2   <= '0;
         prev <= '0;
         cnt  <= '0;
      end else begin
         s1   <= seg_in;
         s2   <= s1;
         prev <= s2;
         if (s2 != prev)
            cnt <= '0;
         else if (cnt != 4'(STABLE_CYCLES))
            cnt <= cnt + 4'd1;
      end
   end

   // Saturating cnt means the match below is seen exactly once per stable run.
   assign accept = (s2 == prev) && (cnt == 4'(STABLE_CYCLES - 1));
   assign pat    = s2;

endmodule

// File: rtl/tt_um_senolgulgonul_segrx.sv
// rtl/tt_um_senolgulgonul_segrx.sv - 7-segment receiver: filters, decodes and tracks the letter sequence
module tt_um_senolgulgonul_segrx
   import segrx_pkg::*;
#(
   parameter int STABLE_CYCLES = 4
) (
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe,
   input  logic       ena,
   input  logic       clk,
   input  logic       rst_n
);

   logic [6:0] pat;
   logic       accept;
   logic [6:0] last_pat;
   sym_t       sym;
   sym_t       code;
   logic [3:0] idx;
   logic [5:0] count;
   logic       done;
   logic       mism;
   logic       unk;
   logic       unused_ok;

   seg_stabilizer #(.STABLE_CYCLES(STABLE_CYCLES)) u_stab (
      .clk    (clk),
      .rst_n  (rst_n),
      .seg_in (ui_in[6:0]),
      .pat    (pat),
      .accept (accept)
   );

   assign code = seg_decode(pat);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_pat <= '0;
         sym      <= SYM_UNK;
         idx      <= '0;
         count    <= '0;
         done     <= 1'b0;
         mism     <= 1'b0;
         unk      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            if (pat == SEG_BLANK) begin
               last_pat <= '0;
            end else if (pat != last_pat) begin
               last_pat <= pat;
               sym      <= code;
               if (code == SYM_UNK) begin
                  unk <= 1'b1;
                  idx <= '0;
               end else if (code == exp_sym(idx)) begin
                  if (idx == SEQ_LAST) begin
                     idx   <= '0;
                     count <= count + 6'd1;
                     done  <= 1'b1;
                  end else begin
                     idx <= idx + 4'd1;
                  end
               end else begin
                  // An out-of-place S is itself a valid sequence start.
                  mism <= 1'b1;
                  idx  <= (code == SYM_S) ? 4'd1 : 4'd0;
               end
            end
         end
      end
   end

   assign uo_out    = {done, sym, idx};
   assign uio_out   = {unk, mism, count};
   assign uio_oe    = 8'hFF;
   assign unused_ok = &{1'b0, ena, ui_in[7], uio_in};

endmodule
